vshift_pipe: RTL

Pipelined, lane-packed vector shifter for the vector ALU datapath. Accepts a DATA_WIDTH-bit operand and a DATA_WIDTH-bit shift vector, splits both into elements of a runtime-selected width (8/16/32 bits), and shifts every element independently: logical left, logical right or arithmetic right. It sits between the operand dispatch and the ALU result mux and uses a valid/ready handshake. Latency is set by a parameter; the pipeline stalls cleanly under backpressure.

---
 rtl/vshift_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vshift_pipe.sv
// vshift_pipe: pipelined, lane-packed vector shifter.
//
// The operand and shift vector are split into 8/16/32-bit elements, selected
// per operation by sew_i. Each element is shifted on its own: logical left,
// logical right or arithmetic right. Only the low log2(E) bits of each
// shift element are used. The shift is computed in front of stage 1. The
// remaining stages only carry the result forward under a valid/ready
// handshake.
//
// Optional feature macro: VSHIFT_PIPE_ROTATE_EN
//   defined   - op_i=11 rotates each element right; illegal_o stays 0 for it
//   undefined - op_i=11 gives an all-zero result and sets illegal_o
//
// Parameters:
//   DATA_WIDTH  operand/result width, a multiple of 32
//   STAGES      pipeline depth, 1..3
// Ports:
//   module_clk_i   clock, rising edge
//   module_rst_ni  asynchronous active-low reset (clears valid bits only)
//   valid_i/ready_o               input handshake
//   sew_i, op_i, a_i, shift_i     operation payload
//   valid_o/ready_i               output handshake
//   result_o, illegal_o           result, forced to 0 while valid_o=0
module vshift_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                  module_clk_i,
    input  logic                  module_rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [1:0]            sew_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] shift_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  illegal_o
);

    localparam int LAST = STAGES - 1;

    logic [DATA_WIDTH-1:0] w_res_e [3];
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_ill;
    logic [STAGES-1:0]     w_load;
    logic                  w_unused_shift;

    logic [STAGES-1:0]     r_vld;
    logic [DATA_WIDTH-1:0] r_res [STAGES];
    logic                  r_ill [STAGES];

    // Each element width gets its own lane array. The result is picked by
    // sew_i afterwards. Lanes never see their neighbours' bits.
    for (genvar g = 0; g < 3; g++) begin : g_width
        localparam int E  = 8 << g;
        localparam int SW = 3 + g;
        for (genvar k = 0; k < DATA_WIDTH / E; k++) begin : g_elem
            logic [E-1:0]  w_a;
            logic [E-1:0]  w_out;
            logic [SW-1:0] w_s;
            assign w_a = a_i[k*E +: E];
            assign w_s = shift_i[k*E +: SW];
`ifdef VSHIFT_PIPE_ROTATE_EN
            // Rotate as a shift of the element concatenated with itself.
            logic [2*E-1:0] w_rot;
            assign w_rot = {w_a, w_a} >> w_s;
`endif
            always_comb begin
                w_out = '0;
                case (op_i)
                    2'b00:   w_out = w_a << w_s;
                    2'b01:   w_out = w_a >> w_s;
                    2'b10:   w_out = $signed(w_a) >>> w_s;
`ifdef VSHIFT_PIPE_ROTATE_EN
                    default: w_out = w_rot[E-1:0];
`else
                    default: w_out = '0;
`endif
                endcase
            end
            assign w_res_e[g][k*E +: E] = w_out;
        end
    end

    // The upper bits of each shift element are masked off by design.
    assign w_unused_shift = ^shift_i;

    // The reserved sew value is computed as 32-bit elements.
    always_comb begin
        w_sel = w_res_e[2];
        case (sew_i)
            2'b00:   w_sel = w_res_e[0];
            2'b01:   w_sel = w_res_e[1];
            default: w_sel = w_res_e[2];
        endcase
    end

`ifdef VSHIFT_PIPE_ROTATE_EN
    assign w_ill = (sew_i == 2'b11);
`else
    assign w_ill = (sew_i == 2'b11) || (op_i == 2'b11);
`endif

    // Stage n loads when it is empty or when stage n+1 loads. The last stage
    // loads when ready_i=1. Unrolled from the output end, so each bit is
    // ready_i OR'ed with any empty stage at or after it.
    always_comb begin : p_load
        logic v_acc;
        w_load = '0;
        v_acc  = ready_i;
        for (int n = LAST; n >= 0; n--) begin
            v_acc     = v_acc | ~r_vld[n];
            w_load[n] = v_acc;
        end
    end

    assign ready_o = w_load[0];

    always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
        if (!module_rst_ni) begin
            r_vld <= '0;
        end else begin
            if (w_load[0]) r_vld[0] <= valid_i;
            for (int n = 1; n < STAGES; n++) begin
                if (w_load[n]) r_vld[n] <= r_vld[n-1];
            end
        end
    end

    // Payload is not reset. The output gating below hides stale contents.
    always_ff @(posedge module_clk_i) begin
        if (w_load[0]) begin
            r_res[0] <= w_sel;
            r_ill[0] <= w_ill;
        end
        for (int n = 1; n < STAGES; n++) begin
            if (w_load[n]) begin
                r_res[n] <= r_res[n-1];
                r_ill[n] <= r_ill[n-1];
            end
        end
    end

    assign valid_o   = r_vld[LAST];
    assign result_o  = valid_o ? r_res[LAST] : '0;
    assign illegal_o = valid_o & r_ill[LAST];

endmodule
